// File: rtl/uart_rx_pkg.sv
// UART receiver shared types: FSM state encoding and legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    // Any ratio other than 16 or 32 falls back to 8x oversampling.
    function automatic int unsigned legal_presc(input int unsigned p);
        return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Tick-within-bit and data-bit counters for the UART receiver, driven by the FSM.
module uart_rx_edge_bit_cnt #(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_clr,
    input  logic               cnt_en,
    input  logic               bit_inc,
    input  logic               bit_clr,
    input  logic [PRESC_W-1:0] presc_last,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               bit_end_c
);

    // Last tick of the current bit period.
    assign bit_end_c = (edge_cnt == presc_last);

    // Edge counter wraps at the bit end; bit counter steps or clears on FSM request.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            edge_cnt <= bit_end_c ? '0 : edge_cnt + PRESC_W'(1);
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bits and reports frame status.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stop_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               data_sampled,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_check_en,
    output logic               stop_chk_en,
    output logic               data_valid,
    output logic               frame_err,
    output logic               busy
);

    rx_state_e          state, state_nxt;
    logic               sticky_err, sticky_nxt;
    logic               dv_nxt, fe_nxt;
    logic               latch_presc;
    logic               cnt_clr, bit_inc, bit_clr;
    logic               bit_end_c;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_lat;
    logic [PRESC_W-1:0] presc_last;
    logic [PRESC_W-1:0] samp_pt;

    assign presc_lat  = PRESC_W'(legal_presc(32'(prescale)));
    assign presc_last = presc_q - PRESC_W'(1);
    assign samp_pt    = (presc_q >> 1) + PRESC_W'(1);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .cnt_clr    (cnt_clr),
        .cnt_en     (busy),
        .bit_inc    (bit_inc),
        .bit_clr    (bit_clr),
        .presc_last (presc_last),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .bit_end_c  (bit_end_c)
    );

    // State, sticky parity flag, latched ratio and frame-result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sticky_err <= 1'b0;
            presc_q    <= PRESC_W'(PRESC_8);
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sticky_err <= sticky_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
            if (latch_presc) begin
                presc_q <= presc_lat;
            end
        end
    end

    // Next-state and counter control; checker results are only looked at on bit ends.
    always_comb begin
        state_nxt   = state;
        sticky_nxt  = sticky_err;
        dv_nxt      = 1'b0;
        fe_nxt      = 1'b0;
        latch_presc = 1'b0;
        cnt_clr     = 1'b0;
        bit_inc     = 1'b0;
        bit_clr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_in) begin
                    state_nxt   = START;
                    cnt_clr     = 1'b1;
                    latch_presc = 1'b1;
                    sticky_nxt  = 1'b0;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_nxt = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                        bit_clr   = 1'b1;
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    sticky_nxt = par_err;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (!sticky_err && !stop_err) begin
                        dv_nxt = 1'b1;
                    end else begin
                        fe_nxt = 1'b1;
                    end
                    if (!rx_in) begin
                        state_nxt   = START;
                        cnt_clr     = 1'b1;
                        latch_presc = 1'b1;
                        sticky_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Enables and sample strobe decoded from registered state and counters only.
    always_comb begin
        busy         = (state != IDLE);
        data_sampled = busy && (edge_cnt == samp_pt);
        strt_chk_en  = (state == START);
        deser_en     = (state == DATA) && data_sampled;
        par_check_en = (state == PARITY);
        stop_chk_en  = (state == STOP);
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: cycle-accurate frame-level reference model.
module tb_uart_rx_fsm;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          strt_glitch;
    logic          par_err;
    logic          stop_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          data_sampled;
    logic          strt_chk_en;
    logic          deser_en;
    logic          par_check_en;
    logic          stop_chk_en;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    logic pend_dv   = 1'b0;
    logic pend_fe   = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fsm #(
        .DATA_WIDTH (DW),
        .PRESC_W    (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .par_en       (par_en),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stop_err     (stop_err),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .data_sampled (data_sampled),
        .strt_chk_en  (strt_chk_en),
        .deser_en     (deser_en),
        .par_check_en (par_check_en),
        .stop_chk_en  (stop_chk_en),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    function automatic int unsigned eff_presc(input int unsigned raw);
        return (raw == 16 || raw == 32) ? raw : 8;
    endfunction

    function automatic logic [17:0] mk(input logic bz, input logic st, input logic de,
                                       input logic pc, input logic sc, input logic ds,
                                       input logic dv, input logic fe,
                                       input int unsigned ec, input int unsigned bc);
        return {bz, st, de, pc, sc, ds, dv, fe, 6'(ec), 4'(bc)};
    endfunction

    task automatic check_cycle(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {busy, strt_chk_en, deser_en, par_check_en, stop_chk_en, data_sampled,
               data_valid, frame_err, edge_cnt, bit_cnt};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rx_in    = 1'b1;
            prescale = PW'($urandom_range(0, 63));
            tick();
            check_cycle("idle", mk(0, 0, 0, 0, 0, 0, pend_dv, pend_fe, 0, 0));
            pend_dv = 1'b0;
            pend_fe = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rx_in = 1'b1;
        tick();
        pend_dv = 1'b0;
        pend_fe = 1'b0;
        check_cycle("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
    endtask

    // One frame starting at the edge where rx_in is first sampled low (k = 0).
    // abort_at > 0 stops driving after that many cycles without scheduling a result.
    task automatic run_frame(input int unsigned raw, input logic [DW-1:0] data,
                             input logic pen, input logic glitch, input logic perr,
                             input logic serr, input int abort_at, input string tag);
        int unsigned p, n, b, e, lim;
        logic samp, bit_v;
        p   = eff_presc(raw);
        n   = glitch ? p : (2 + DW + 32'(pen)) * p;
        lim = (abort_at > 0) ? 32'(abort_at) : n;
        for (int unsigned k = 0; k < lim; k++) begin
            b = k / p;
            e = k % p;
            if (glitch)              bit_v = (k >= 3);
            else if (b == 0)         bit_v = 1'b0;
            else if (b <= DW)        bit_v = data[b-1];
            else if (pen && b == DW + 1) bit_v = ^data;
            else                     bit_v = 1'b1;
            rx_in    = bit_v;
            prescale = (k == 0) ? PW'(raw) : PW'($urandom_range(0, 63));
            par_en   = (k < p) ? 1'($urandom) : pen;
            if (k >= 1) begin
                strt_glitch = glitch;
                par_err     = perr;
                stop_err    = serr;
            end
            tick();
            samp = (e == p / 2 + 1);
            check_cycle(tag, mk(1, b == 0, samp && b >= 1 && b <= DW,
                                pen && !glitch && b == DW + 1,
                                !glitch && b == DW + 1 + 32'(pen), samp,
                                pend_dv, pend_fe, e,
                                (b >= 1 && b <= DW) ? b - 1 : 0));
            pend_dv = 1'b0;
            pend_fe = 1'b0;
        end
        if (abort_at == 0 && !glitch) begin
            if ((pen && perr) || serr) pend_fe = 1'b1;
            else                       pend_dv = 1'b1;
        end
    endtask

    initial begin
        int unsigned raw, pick;
        logic g, prev_glitch;
        rst         = 1'b1;
        rx_in       = 1'b1;
        prescale    = PW'(8);
        par_en      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stop_err    = 1'b0;
        tick();
        do_reset();
        idle_cycles(3);

        // 8x, 0xA5 with parity: data_valid lands 88 cycles after the start edge.
        run_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0, "p8_a5");
        idle_cycles(2);

        // 16x with parity error: STOP still visited, frame_err only.
        run_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 0, "p16_perr");
        idle_cycles(2);

        // Short low pulse rejected by the start checker.
        run_frame(16, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, "glitch");
        idle_cycles(3);

        // Back-to-back 32x frames without parity.
        run_frame(32, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0, "b2b_a");
        run_frame(32, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0, "b2b_b");
        idle_cycles(2);

        // Reset during data bit 4, then a clean frame.
        run_frame(16, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5 * 16 + 3, "abort");
        do_reset();
        idle_cycles(2);
        run_frame(16, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 0, "after_rst");
        idle_cycles(2);

        // Illegal ratio 5 behaves as 8x.
        run_frame(5, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 0, "p5");
        idle_cycles(2);

        // Stop error with parity clean.
        run_frame(8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 0, "serr");
        idle_cycles(1);

        // Randomized frames, gaps and checker outcomes.
        prev_glitch = 1'b0;
        for (int i = 0; i < 24; i++) begin
            pick = $urandom_range(0, 3);
            raw  = (pick == 0) ? 8 : (pick == 1) ? 16 : (pick == 2) ? 32 : $urandom_range(0, 63);
            g    = ($urandom_range(0, 7) == 0);
            if (prev_glitch) idle_cycles(1 + $urandom_range(0, 2));
            else             idle_cycles($urandom_range(0, 3));
            run_frame(raw, 8'($urandom_range(0, 255)), 1'($urandom), g,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0, "rand");
            prev_glitch = g;
        end
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
